controlador_param: RTL and testbench

Parametrised successor of the parking-gate controller.
- Detects a vehicle at the entry sensor and validates a PIN of configurable width.
- Opens the gate on a correct PIN and closes it once the vehicle has passed.
- Raises a wrong-PIN alarm after a configurable number of failures, and a lockout alarm on tailgating.
- New behaviour: PIN-entry timeout, attempt-count output, and a saturating passed-vehicle counter.

---
 rtl/controlador_pkg.sv | 14 +
 rtl/contador_saturado.sv | 25 ++
 rtl/controlador_param.sv | 155 +++++++++++++++
 tb/tb_controlador_param.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/controlador_pkg.sv
// Shared state encoding and default PIN for the parking-gate controller.
package controlador_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ESPERA_PIN = 3'd1,
        ALARMA_PIN = 3'd2,
        ABIERTO    = 3'd3,
        BLOQUEO    = 3'd4
    } state_t;

    localparam logic [7:0] DEFAULT_CORRECT_PIN = 8'hA5;

endpackage

// File: rtl/contador_saturado.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Latency: one cycle. No backpressure: holds at MAX_VAL instead of wrapping.
// Counter state is reset asynchronously to zero.
module contador_saturado #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX_VAL)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/controlador_param.sv
// Parking-gate controller: PIN check, gate open/close, wrong-PIN and tailgate alarms.
// Latency: every output registered, one cycle after the causing input.
// No backpressure: pin_validation is a strobe, a held strobe counts once per cycle.
module controlador_param
    import controlador_pkg::*;
#(
    parameter int                   PIN_WIDTH     = 8,
    parameter logic [PIN_WIDTH-1:0] CORRECT_PIN   = PIN_WIDTH'(DEFAULT_CORRECT_PIN),
    parameter int                   MAX_ATTEMPTS  = 3,
    parameter int                   ENTRY_TIMEOUT = 16,
    parameter int                   CNT_WIDTH     = 8,
    localparam int                  ATT_W         = $clog2(MAX_ATTEMPTS + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sensor_a,
    input  logic                 sensor_b,
    input  logic                 pin_validation,
    input  logic [PIN_WIDTH-1:0] pin,
    output logic                 alarma_pin_incorrecto,
    output logic                 alarma_bloqueo,
    output logic                 senal_abrir_compuerta,
    output logic                 senal_cerrar_compuerta,
    output logic [ATT_W-1:0]     intentos,
    output logic [CNT_WIDTH-1:0] vehiculos,
    output logic                 timeout_pin
);

    localparam int               TMR_W     = $clog2(ENTRY_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(ENTRY_TIMEOUT - 1);
    localparam logic [ATT_W-1:0] ATT_MAX   = ATT_W'(MAX_ATTEMPTS);
    localparam logic [ATT_W-1:0] ATT_LAST  = ATT_W'(MAX_ATTEMPTS - 1);

    state_t           state_q;
    state_t           state_d;
    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;
    logic             att_clr;
    logic             att_inc;
    logic             veh_inc;
    logic             timeout_d;
    logic             pin_ok;

    assign pin_ok = (pin == CORRECT_PIN);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        att_clr   = 1'b0;
        att_inc   = 1'b0;
        veh_inc   = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sensor_a) begin
                    state_d = ESPERA_PIN;
                    att_clr = 1'b1;
                    timer_d = '0;
                end
            end
            ESPERA_PIN: begin
                // A strobe on the last timer cycle takes precedence over the timeout.
                if (pin_validation) begin
                    if (pin_ok) begin
                        state_d = ABIERTO;
                        att_clr = 1'b1;
                    end else begin
                        att_inc = 1'b1;
                        timer_d = '0;
                        if (intentos == ATT_LAST) begin
                            state_d = ALARMA_PIN;
                        end
                    end
                end else if (timer_q == TMR_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                    att_clr   = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ALARMA_PIN: begin
                if (pin_validation && pin_ok) begin
                    state_d = ABIERTO;
                    att_clr = 1'b1;
                end
            end
            ABIERTO: begin
                if (sensor_a && sensor_b) begin
                    state_d = BLOQUEO;
                end else if (sensor_b) begin
                    state_d = IDLE;
                    veh_inc = 1'b1;
                end
            end
            BLOQUEO: begin
                if (pin_validation && pin_ok) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            senal_abrir_compuerta  <= 1'b0;
            senal_cerrar_compuerta <= 1'b1;
            alarma_pin_incorrecto  <= 1'b0;
            alarma_bloqueo         <= 1'b0;
            timeout_pin            <= 1'b0;
        end else begin
            senal_abrir_compuerta  <= (state_d == ABIERTO);
            senal_cerrar_compuerta <= (state_d != ABIERTO);
            alarma_pin_incorrecto  <= (state_d == ALARMA_PIN);
            alarma_bloqueo         <= (state_d == BLOQUEO);
            timeout_pin            <= timeout_d;
        end
    end

    contador_saturado #(
        .WIDTH   (ATT_W),
        .MAX_VAL (ATT_MAX)
    ) u_intentos (
        .clock (clock),
        .reset (reset),
        .clr   (att_clr),
        .inc   (att_inc),
        .count (intentos)
    );

    contador_saturado #(
        .WIDTH (CNT_WIDTH)
    ) u_vehiculos (
        .clock (clock),
        .reset (reset),
        .clr   (1'b0),
        .inc   (veh_inc),
        .count (vehiculos)
    );

endmodule

// File: tb/tb_controlador_param.sv
// Bench for controlador_param: directed scenarios plus random traffic against a rule-level model.
module tb_controlador_param;

    localparam int         MAXA = 3;
    localparam int         TOUT = 16;
    localparam int         VMAX = 3;
    localparam logic [7:0] GOOD = 8'hA5;

    logic       clock = 1'b0;
    logic       reset;
    logic       sensor_a, sensor_b, pin_validation;
    logic [7:0] pin;
    logic       alarma_pin_incorrecto, alarma_bloqueo;
    logic       senal_abrir_compuerta, senal_cerrar_compuerta;
    logic [1:0] intentos;
    logic [1:0] vehiculos;
    logic       timeout_pin;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    controlador_param #(
        .PIN_WIDTH     (8),
        .CORRECT_PIN   (GOOD),
        .MAX_ATTEMPTS  (MAXA),
        .ENTRY_TIMEOUT (TOUT),
        .CNT_WIDTH     (2)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .sensor_a               (sensor_a),
        .sensor_b               (sensor_b),
        .pin_validation         (pin_validation),
        .pin                    (pin),
        .alarma_pin_incorrecto  (alarma_pin_incorrecto),
        .alarma_bloqueo         (alarma_bloqueo),
        .senal_abrir_compuerta  (senal_abrir_compuerta),
        .senal_cerrar_compuerta (senal_cerrar_compuerta),
        .intentos               (intentos),
        .vehiculos              (vehiculos),
        .timeout_pin            (timeout_pin)
    );

    // Reference model: what the gate is doing, and plain integer counts.
    typedef enum {M_IDLE, M_WAIT, M_PINALARM, M_OPEN, M_LOCK} mode_e;
    mode_e m_mode;
    int    m_att, m_veh, m_idle_cycles;
    bit    m_pulse;

    function automatic void model_reset();
        m_mode = M_IDLE; m_att = 0; m_veh = 0; m_idle_cycles = 0; m_pulse = 0;
    endfunction

    function automatic void model_step(bit a, bit b, bit v, logic [7:0] p);
        bit ok = v && (p == GOOD);
        m_pulse = 0;
        case (m_mode)
            M_IDLE: if (a) begin m_mode = M_WAIT; m_att = 0; m_idle_cycles = 0; end
            M_WAIT: begin
                if (ok) begin
                    m_mode = M_OPEN; m_att = 0;
                end else if (v) begin
                    m_att++; m_idle_cycles = 0;
                    if (m_att == MAXA) m_mode = M_PINALARM;
                end else begin
                    m_idle_cycles++;
                    if (m_idle_cycles == TOUT) begin m_mode = M_IDLE; m_pulse = 1; m_att = 0; end
                end
            end
            M_PINALARM: if (ok) begin m_mode = M_OPEN; m_att = 0; end
            M_OPEN: begin
                if (a && b) m_mode = M_LOCK;
                else if (b) begin m_mode = M_IDLE; m_veh = (m_veh + 1 > VMAX) ? VMAX : m_veh + 1; end
            end
            M_LOCK: if (ok) m_mode = M_IDLE;
            default: m_mode = M_IDLE;
        endcase
    endfunction

    // Packed view {abrir, cerrar, alarma_pin, alarma_bloqueo, intentos, vehiculos, timeout}.
    function automatic logic [8:0] expv();
        logic op = (m_mode == M_OPEN);
        return {op, !op, m_mode == M_PINALARM, m_mode == M_LOCK, 2'(m_att), 2'(m_veh), m_pulse};
    endfunction

    function automatic logic [8:0] obsv();
        return {senal_abrir_compuerta, senal_cerrar_compuerta, alarma_pin_incorrecto,
                alarma_bloqueo, intentos, vehiculos, timeout_pin};
    endfunction

    task automatic cycle(input bit a, input bit b, input bit v, input logic [7:0] p);
        @(negedge clock);
        sensor_a = a; sensor_b = b; pin_validation = v; pin = p;
        @(posedge clock);
        model_step(a, b, v, p);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; sensor_a = 0; sensor_b = 0; pin_validation = 0; pin = 8'h00;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        total++;
        if (obsv() !== 9'b0_1_0_0_00_00_0) begin
            bad++; $display("FAIL reset_state: got %b want %b", obsv(), 9'b010000000);
        end
        @(negedge clock);
        reset = 1'b1;
        cycle(0, 0, 0, 8'h00);
        total++;
        if (obsv() !== expv()) begin bad++; $display("FAIL reset_release: got %b want %b", obsv(), expv()); end
    endtask

    task automatic test_open_and_pass();
        cycle(1, 0, 0, 8'h00);
        cycle(0, 0, 1, GOOD);
        total++;
        if (senal_abrir_compuerta !== 1'b1 || obsv() !== expv()) begin
            bad++; $display("FAIL open_on_good_pin: got %b want %b", obsv(), expv());
        end
        cycle(0, 1, 0, 8'h00);
        total++;
        if (vehiculos !== 2'd1 || obsv() !== expv()) begin
            bad++; $display("FAIL close_after_pass: got %b want %b", obsv(), expv());
        end
    endtask

    task automatic test_wrong_pins();
        cycle(1, 0, 0, 8'h00);
        for (int i = 1; i <= MAXA; i++) begin
            cycle(0, 0, 1, 8'h11);
            total++;
            if (intentos !== 2'(i) || obsv() !== expv()) begin
                bad++; $display("FAIL wrong_pin_%0d: got %b want %b", i, obsv(), expv());
            end
        end
        cycle(0, 0, 1, 8'hA4);
        total++;
        if (alarma_pin_incorrecto !== 1'b1 || obsv() !== expv()) begin
            bad++; $display("FAIL alarm_holds: got %b want %b", obsv(), expv());
        end
        cycle(0, 0, 1, GOOD);
        total++;
        if (obsv() !== expv()) begin bad++; $display("FAIL alarm_clear_open: got %b want %b", obsv(), expv()); end
    endtask

    task automatic test_tailgate();
        cycle(1, 1, 0, 8'h00);
        total++;
        if (alarma_bloqueo !== 1'b1 || obsv() !== expv()) begin
            bad++; $display("FAIL tailgate_lock: got %b want %b", obsv(), expv());
        end
        cycle(0, 0, 1, 8'h00);
        cycle(0, 0, 1, 8'h25);
        total++;
        if (obsv() !== expv()) begin bad++; $display("FAIL lock_ignores_wrong: got %b want %b", obsv(), expv()); end
        cycle(0, 0, 1, GOOD);
        total++;
        if (alarma_bloqueo !== 1'b0 || obsv() !== expv()) begin
            bad++; $display("FAIL lock_exit: got %b want %b", obsv(), expv());
        end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        cycle(1, 0, 0, 8'h00);
        for (int i = 0; i < TOUT + 2; i++) begin
            cycle(0, 0, 0, 8'h00);
            pulses += int'(timeout_pin);
            total++;
            if (obsv() !== expv()) begin bad++; $display("FAIL timeout_cycle_%0d: got %b want %b", i, obsv(), expv()); end
        end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL timeout_pulse_count: got %0d want 1", pulses); end
        cycle(1, 0, 0, 8'h00);
        repeat (TOUT - 1) cycle(0, 0, 0, 8'h00);
        cycle(0, 0, 1, GOOD);
        total++;
        if (senal_abrir_compuerta !== 1'b1 || timeout_pin !== 1'b0 || obsv() !== expv()) begin
            bad++; $display("FAIL strobe_beats_timeout: got %b want %b", obsv(), expv());
        end
        cycle(0, 1, 0, 8'h00);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 0, 8'h00);
            cycle(0, 0, 1, GOOD);
            cycle(0, 1, 0, 8'h00);
            total++;
            if (obsv() !== expv()) begin bad++; $display("FAIL vehicle_%0d: got %b want %b", i, obsv(), expv()); end
        end
        total++;
        if (vehiculos !== 2'd3) begin bad++; $display("FAIL saturation: got %0d want 3", vehiculos); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            logic [7:0] p;
            case ($urandom_range(0, 2))
                0:       p = GOOD;
                1:       p = GOOD ^ (8'h01 << $urandom_range(0, 7));
                default: p = 8'($urandom);
            endcase
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, p);
            total++;
            if (obsv() !== expv()) begin bad++; $display("FAIL random_%0d: got %b want %b", i, obsv(), expv()); end
        end
    endtask

    task automatic test_async_reset();
        cycle(1, 0, 0, 8'h00);
        cycle(0, 0, 1, GOOD);
        @(posedge clock);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        total++;
        if (obsv() !== 9'b0_1_0_0_00_00_0) begin
            bad++; $display("FAIL async_reset: got %b want %b", obsv(), 9'b010000000);
        end
        @(negedge clock);
        reset = 1'b1;
        cycle(0, 0, 0, 8'h00);
        total++;
        if (obsv() !== expv()) begin bad++; $display("FAIL after_async_reset: got %b want %b", obsv(), expv()); end
    endtask

    initial begin
        test_reset();
        test_open_and_pass();
        test_wrong_pins();
        test_tailgate();
        test_timeout();
        test_saturate();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
